multi_ch_pattern_pwm: RTL and testbench

Parametrised multi-channel pattern PWM engine. Successor to the fixed 3-channel fast/slow PWM set driven from the UART register mapper.
Each channel serialises a PAT_WIDTH-bit pattern MSB-first, with a programmable bit length, repeat count and inter-repeat gap. It supports continuous mode, broadcast commands and shadowed reloads.
It sits between the UART register mapper (config write port) and the OBUF/OBUFDS output primitives (pwm_out).

---
 rtl/multi_ch_pattern_pwm.sv | 206 ++++++++++++++++++++
 tb/tb_multi_ch_pattern_pwm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_pattern_pwm.sv
// Multi-channel pattern PWM: each channel shifts out a pattern MSB-first with shadowed reloads.
// Optional build macro PWM_SYNC_START_EN adds sync_start; START then arms and sync_start launches.
module multi_ch_pattern_pwm #(
    parameter int CH_NUM    = 4,
    parameter int PAT_WIDTH = 32,
    parameter int LEN_WIDTH = 8,
    parameter int GAP_WIDTH = 17,
    parameter int REP_WIDTH = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cfg_wr,
    input  logic [7:0]           cfg_ch,
    input  logic [1:0]           cfg_cmd,
    input  logic [PAT_WIDTH-1:0] cfg_pat,
    input  logic [LEN_WIDTH-1:0] cfg_bit_len,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic [REP_WIDTH-1:0] cfg_rep,
`ifdef PWM_SYNC_START_EN
    input  logic                 sync_start,
`endif
    output logic                 cfg_ack,
    output logic                 cfg_err,
    output logic [CH_NUM-1:0]    pwm_out,
    output logic [CH_NUM-1:0]    pwm_busy,
    output logic [CH_NUM-1:0]    pwm_valid,
    output logic [CH_NUM-1:0]    pwm_done
);
    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_WIDTH - 1);
    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_LDST  = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, ARMED} state_t;

    function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? LEN_WIDTH'(1) : len;
    endfunction

    logic cfg_bcast;
    logic cfg_ok;
    assign cfg_bcast = (cfg_ch == 8'hFF);
    assign cfg_ok    = cfg_wr && (cfg_bcast || (32'(cfg_ch) < CH_NUM));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_ok;
            cfg_err <= cfg_wr && !cfg_ok;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        state_t               state;
        logic [PAT_WIDTH-1:0] sh_pat, act_pat, nx_pat;
        logic [LEN_WIDTH-1:0] sh_len, act_len, nx_len, len_cnt;
        logic [GAP_WIDTH-1:0] sh_gap, act_gap, nx_gap, gap_cnt;
        logic [REP_WIDTH-1:0] sh_rep, act_rep, nx_rep, rep_cnt, rep_inc;
        logic [IDX_W-1:0]     idx;
        logic                 out_q, busy_q, valid_q, done_q;
        logic                 hit, is_load, is_start, is_stop;

        assign hit      = cfg_ok && (cfg_bcast || cfg_ch == 8'(i));
        assign is_load  = hit && (cfg_cmd == CMD_LOAD || cfg_cmd == CMD_LDST);
        assign is_start = hit && (cfg_cmd == CMD_START || cfg_cmd == CMD_LDST);
        assign is_stop  = hit && (cfg_cmd == CMD_STOP);

        // Shadow as it will stand after this edge, so a same-cycle LOAD reaches a boundary reload
        assign nx_pat  = is_load ? cfg_pat     : sh_pat;
        assign nx_len  = is_load ? cfg_bit_len : sh_len;
        assign nx_gap  = is_load ? cfg_gap     : sh_gap;
        assign nx_rep  = is_load ? cfg_rep     : sh_rep;
        assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state   <= IDLE;
                sh_pat  <= '0;
                sh_len  <= LEN_WIDTH'(1);
                sh_gap  <= '0;
                sh_rep  <= REP_WIDTH'(1);
                act_pat <= '0;
                act_len <= LEN_WIDTH'(1);
                act_gap <= '0;
                act_rep <= REP_WIDTH'(1);
                len_cnt <= '0;
                gap_cnt <= '0;
                rep_cnt <= '0;
                idx     <= '0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state)
                    SHIFT: begin
                        if (len_cnt > LEN_WIDTH'(1)) begin
                            len_cnt <= len_cnt - 1'b1;
                        end else if (idx != '0) begin
                            idx     <= idx - 1'b1;
                            len_cnt <= eff_len(act_len);
                            out_q   <= act_pat[idx - 1'b1];
                        end else begin
                            rep_cnt <= rep_inc;
                            if (act_rep != '0 && rep_inc == act_rep) begin
                                state   <= IDLE;
                                out_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b1;
                                done_q  <= 1'b1;
                            end else if (act_gap != '0) begin
                                state   <= GAP;
                                gap_cnt <= act_gap;
                                out_q   <= 1'b0;
                            end else begin
                                act_pat <= nx_pat;
                                act_len <= nx_len;
                                act_gap <= nx_gap;
                                act_rep <= nx_rep;
                                idx     <= IDX_MSB;
                                len_cnt <= eff_len(nx_len);
                                out_q   <= nx_pat[PAT_WIDTH-1];
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt > GAP_WIDTH'(1)) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else begin
                            state   <= SHIFT;
                            act_pat <= nx_pat;
                            act_len <= nx_len;
                            act_gap <= nx_gap;
                            act_rep <= nx_rep;
                            idx     <= IDX_MSB;
                            len_cnt <= eff_len(nx_len);
                            out_q   <= nx_pat[PAT_WIDTH-1];
                        end
                    end
`ifdef PWM_SYNC_START_EN
                    ARMED: begin
                        if (sync_start) begin
                            state   <= SHIFT;
                            idx     <= IDX_MSB;
                            len_cnt <= eff_len(act_len);
                            out_q   <= act_pat[PAT_WIDTH-1];
                        end
                    end
`endif
                    default: ;
                endcase

                // Config writes override whatever the run logic decided this cycle
                if (is_load) begin
                    sh_pat  <= cfg_pat;
                    sh_len  <= cfg_bit_len;
                    sh_gap  <= cfg_gap;
                    sh_rep  <= cfg_rep;
                    valid_q <= 1'b0;
                    if (state == IDLE) begin
                        act_pat <= cfg_pat;
                        act_len <= cfg_bit_len;
                        act_gap <= cfg_gap;
                        act_rep <= cfg_rep;
                    end
                end
                if (is_start) begin
                    act_pat <= nx_pat;
                    act_len <= nx_len;
                    act_gap <= nx_gap;
                    act_rep <= nx_rep;
                    rep_cnt <= '0;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
`ifdef PWM_SYNC_START_EN
                    state   <= ARMED;
                    out_q   <= 1'b0;
`else
                    state   <= SHIFT;
                    idx     <= IDX_MSB;
                    len_cnt <= eff_len(nx_len);
                    out_q   <= nx_pat[PAT_WIDTH-1];
`endif
                end
                if (is_stop) begin
                    state   <= IDLE;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= valid_q;
                end
            end
        end

        assign pwm_out[i]   = out_q;
        assign pwm_busy[i]  = busy_q;
        assign pwm_valid[i] = valid_q;
        assign pwm_done[i]  = done_q;
    end
endmodule

// File: tb/tb_multi_ch_pattern_pwm.sv
// Bench for multi_ch_pattern_pwm: table of configs plus random runs checked against a waveform model.
module tb_multi_ch_pattern_pwm;
    localparam int CH = 4;
    localparam logic [1:0] C_LOAD = 2'b00, C_START = 2'b01, C_STOP = 2'b10, C_LDST = 2'b11;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [7:0]    cfg_ch = '0;
    logic [1:0]    cfg_cmd = '0;
    logic [31:0]   cfg_pat = '0;
    logic [7:0]    cfg_bit_len = '0;
    logic [16:0]   cfg_gap = '0;
    logic [7:0]    cfg_rep = '0;
    logic          cfg_ack, cfg_err;
    logic [CH-1:0] pwm_out, pwm_busy, pwm_valid, pwm_done;
`ifdef PWM_SYNC_START_EN
    logic          sync_start = 1'b0;
`endif

    multi_ch_pattern_pwm dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_cmd(cfg_cmd), .cfg_pat(cfg_pat), .cfg_bit_len(cfg_bit_len),
        .cfg_gap(cfg_gap), .cfg_rep(cfg_rep),
`ifdef PWM_SYNC_START_EN
        .sync_start(sync_start),
`endif
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .pwm_out(pwm_out),
        .pwm_busy(pwm_busy), .pwm_valid(pwm_valid), .pwm_done(pwm_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    typedef struct {
        int          ch;
        logic [31:0] pat;
        int          len;
        int          gap;
        int          rep;
        int          exp_busy;
        int          exp_high;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] ch, input logic [1:0] cmd, input logic [31:0] pat,
                            input logic [7:0] len, input logic [16:0] gap, input logic [7:0] rep);
        cfg_ch = ch; cfg_cmd = cmd; cfg_pat = pat;
        cfg_bit_len = len; cfg_gap = gap; cfg_rep = rep;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Expected output stream for a finite run, built straight from the pattern rules
    task automatic model_wave(input logic [31:0] pat, input int len, input int gap, input int rep);
        int l;
        l = (len == 0) ? 1 : len;
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = 31; b >= 0; b--)
                for (int k = 0; k < l; k++) exp_q.push_back(pat[b]);
            if (r < rep - 1)
                for (int k = 0; k < gap; k++) exp_q.push_back(1'b0);
        end
    endtask

    task automatic run_check(input int ch, input logic [31:0] pat, input int len, input int gap,
                             input int rep, output int busy_n, output int high_n,
                             output int done_n, output int wave_err);
        model_wave(pat, len, gap, rep);
        busy_n = 0; high_n = 0; done_n = 0; wave_err = 0;
        do_write(8'(ch), C_LDST, pat, 8'(len), 17'(gap), 8'(rep));
        while (pwm_busy[ch] && busy_n <= 20000) begin
            if (busy_n >= exp_q.size() || pwm_out[ch] !== exp_q[busy_n]) wave_err++;
            if (pwm_out[ch]) high_n++;
            if (pwm_done[ch]) done_n++;
            busy_n++;
            tick();
        end
        if (pwm_done[ch]) done_n++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int bn, hn, dn, we, n, mis;
        logic [31:0] p1, p2, rp;
        logic exp_bit;

        tbl[0] = '{0, 32'hA000_0001, 2, 0, 1, 64, 6};
        tbl[1] = '{1, 32'h8000_0000, 1, 5, 3, 106, 3};
        tbl[2] = '{2, 32'hFFFF_0000, 0, 0, 2, 64, 32};
        tbl[3] = '{3, 32'h0000_000F, 3, 10, 2, 202, 24};
        tbl[4] = '{0, 32'h0000_0001, 255, 0, 1, 8160, 255};
        tbl[5] = '{1, 32'h5555_5555, 1, 0, 4, 128, 64};

        tick(); tick();
        sys_rst = 1'b0;
        check("reset_out", 64'(pwm_out), 0);
        check("reset_busy", 64'(pwm_busy), 0);
        check("reset_valid", 64'(pwm_valid), 0);
        check("reset_done", 64'(pwm_done), 0);
        check("reset_ack", 64'(cfg_ack), 0);
        check("reset_err", 64'(cfg_err), 0);

        for (int t = 0; t < 6; t++) begin
            run_check(tbl[t].ch, tbl[t].pat, tbl[t].len, tbl[t].gap, tbl[t].rep, bn, hn, dn, we);
            check($sformatf("tbl%0d_busy_len", t), 64'(bn), 64'(tbl[t].exp_busy));
            check($sformatf("tbl%0d_high_cnt", t), 64'(hn), 64'(tbl[t].exp_high));
            check($sformatf("tbl%0d_wave", t), 64'(we), 0);
            check($sformatf("tbl%0d_done_cnt", t), 64'(dn), 1);
            check($sformatf("tbl%0d_valid", t), 64'(pwm_valid[tbl[t].ch]), 1);
            check($sformatf("tbl%0d_out_idle", t), 64'(pwm_out[tbl[t].ch]), 0);
            tick();
            check($sformatf("tbl%0d_done_1cyc", t), 64'(pwm_done[tbl[t].ch]), 0);
        end

        for (int r = 0; r < 6; r++) begin
            int ch, len, gap, rep, sz;
            ch = $urandom_range(0, CH - 1);
            rp = $urandom;
            len = $urandom_range(0, 3);
            gap = $urandom_range(0, 6);
            rep = $urandom_range(1, 3);
            run_check(ch, rp, len, gap, rep, bn, hn, dn, we);
            sz = exp_q.size();
            check($sformatf("rnd%0d_busy_len", r), 64'(bn), 64'(sz));
            check($sformatf("rnd%0d_wave", r), 64'(we), 0);
            check($sformatf("rnd%0d_done_cnt", r), 64'(dn), 1);
        end

        // Continuous run with a mid-pattern reload taking effect at the repetition boundary
        p1 = 32'hF0F0_F0F0;
        p2 = 32'hFFFF_0000;
        mis = 0;
        do_write(8'd2, C_LDST, p1, 8'd1, 17'd0, 8'd0);
        for (int c = 0; c < 76; c++) begin
            if (c < 32)      exp_bit = p1[31 - c];
            else if (c < 64) exp_bit = p2[31 - (c - 32)];
            else             exp_bit = p2[31 - (c - 64)];
            if (pwm_out[2] !== exp_bit || pwm_busy[2] !== 1'b1) mis++;
            if (c == 10) do_write(8'd2, C_LOAD, p2, 8'd1, 17'd0, 8'd0);
            else tick();
        end
        check("cont_reload_wave", 64'(mis), 0);
        check("cont_valid_after_load", 64'(pwm_valid[2]), 0);
        do_write(8'd2, C_STOP, '0, 8'd1, 17'd0, 8'd0);
        dn = 0;
        check("stop_out", 64'(pwm_out[2]), 0);
        check("stop_busy", 64'(pwm_busy[2]), 0);
        check("stop_valid", 64'(pwm_valid[2]), 0);
        for (int k = 0; k < 4; k++) begin
            if (pwm_done[2]) dn++;
            tick();
        end
        check("stop_no_done", 64'(dn), 0);

        do_write(8'(CH), C_START, 32'hFFFF_FFFF, 8'd1, 17'd0, 8'd1);
        check("badch_err", 64'(cfg_err), 1);
        check("badch_ack", 64'(cfg_ack), 0);
        check("badch_busy", 64'(pwm_busy), 0);
        tick();
        check("badch_err_pulse", 64'(cfg_err), 0);

        do_write(8'hFF, C_LDST, 32'hA5A5_0F0F, 8'd2, 17'd3, 8'd0);
        check("bcast_ack", 64'(cfg_ack), 1);
        check("bcast_err", 64'(cfg_err), 0);
        check("bcast_busy", 64'(pwm_busy), 64'hF);
        check("bcast_msb", 64'(pwm_out), 64'hF);
        mis = 0;
        for (int c = 0; c < 80; c++) begin
            if (pwm_out != 4'h0 && pwm_out != 4'hF) mis++;
            tick();
        end
        check("bcast_aligned", 64'(mis), 0);
        do_write(8'hFF, C_STOP, '0, 8'd1, 17'd0, 8'd0);
        check("bcast_stop_busy", 64'(pwm_busy), 0);
        check("bcast_stop_out", 64'(pwm_out), 0);

        // START landing on the completion edge restarts and swallows the done pulse
        do_write(8'd0, C_LDST, 32'hC000_0000, 8'd1, 17'd0, 8'd1);
        for (int k = 0; k < 31; k++) tick();
        do_write(8'd0, C_START, 32'hC000_0000, 8'd1, 17'd0, 8'd1);
        check("restart_no_done", 64'(pwm_done[0]), 0);
        check("restart_busy", 64'(pwm_busy[0]), 1);
        check("restart_msb", 64'(pwm_out[0]), 1);
        check("restart_valid", 64'(pwm_valid[0]), 0);
        n = 0;
        while (pwm_busy[0] && n < 100) begin
            tick();
            n++;
        end
        check("restart_run_len", 64'(n), 32);
        check("restart_done", 64'(pwm_done[0]), 1);

        do_write(8'd1, C_LDST, 32'h8000_0000, 8'd1, 17'd20, 8'd2);
        for (int k = 0; k < 34; k++) tick();
        check("gap_out_low", 64'(pwm_out[1]), 0);
        check("gap_busy", 64'(pwm_busy[1]), 1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("rst_mid_out", 64'(pwm_out), 0);
        check("rst_mid_busy", 64'(pwm_busy), 0);
        check("rst_mid_valid", 64'(pwm_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
